// File: rtl/rgb_stream_gen.sv
// Synthetic RGB frame source feeding the RGB input FIFO with {vsync, hsync, rgb} words.
// Counters and FSM advance only on accepted writes, so a full FIFO freezes the stream in place.
module rgb_stream_gen #(
  parameter int H_ACTIVE = 40,
  parameter int V_ACTIVE = 48,
  parameter int SLICES   = 128,
  parameter int H_BLANK  = 4,
  parameter int V_BLANK  = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_color,
  input  logic        full,
  output logic        wr_en,
  output logic [23:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic [6:0]  slice_cnt,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  localparam int XW = $clog2(H_ACTIVE + H_BLANK + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int VW = $clog2(V_BLANK + 1);
  localparam logic [XW-1:0] X_ACT_LAST = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(H_ACTIVE + H_BLANK - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_ACTIVE - 1);
  localparam logic [6:0]    S_LAST     = 7'(SLICES - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_BLANK - 1);

  typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_ACTIVE, S_HBLANK} state_t;

  state_t          r_state, w_state_nxt;
  logic [XW-1:0]   r_x, w_x_nxt;
  logic [YW-1:0]   r_y, w_y_nxt;
  logic [6:0]      r_s, w_s_nxt;
  logic [VW-1:0]   r_v, w_v_nxt;
  logic [1:0]      r_mode;
  logic [23:0]     r_color;
  logic            w_latch;
  logic [7:0]      w_x8, w_y8, w_r, w_g, w_b;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_s     <= '0;
      r_v     <= '0;
      r_mode  <= '0;
      r_color <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_s     <= w_s_nxt;
      r_v     <= w_v_nxt;
      if (w_latch) begin
        r_mode  <= mode;
        r_color <= solid_color;
      end
    end
  end

  assign wr_en = (r_state != S_IDLE) && !full;

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_s_nxt     = r_s;
    w_v_nxt     = r_v;
    w_latch     = 1'b0;
    if (r_state == S_IDLE) begin
      if (enable) begin
        w_state_nxt = S_VBLANK;
        w_v_nxt     = '0;
      end
    end else if (wr_en) begin
      case (r_state)
        S_VBLANK: begin
          if (r_v == V_LAST) begin
            w_v_nxt = '0;
            // enable is only sampled here, so a frame is never truncated
            if (enable) begin
              w_state_nxt = S_ACTIVE;
              w_latch     = 1'b1;
              w_x_nxt     = '0;
              w_y_nxt     = '0;
              w_s_nxt     = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_v_nxt = r_v + VW'(1);
          end
        end
        S_ACTIVE: begin
          w_x_nxt = r_x + XW'(1);
          if (r_x == X_ACT_LAST) w_state_nxt = S_HBLANK;
        end
        S_HBLANK: begin
          if (r_x == X_LAST) begin
            w_x_nxt = '0;
            if (r_y != Y_LAST) begin
              w_y_nxt     = r_y + YW'(1);
              w_state_nxt = S_ACTIVE;
            end else if (r_s != S_LAST) begin
              w_y_nxt     = '0;
              w_s_nxt     = r_s + 7'd1;
              w_state_nxt = S_ACTIVE;
            end else begin
              w_state_nxt = S_VBLANK;
              w_v_nxt     = '0;
            end
          end else begin
            w_x_nxt = r_x + XW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_x8 = 8'(r_x);
  assign w_y8 = 8'(r_y);

  // Pattern arithmetic is deliberately mod 256 on every channel
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (r_mode)
      2'd0: {w_r, w_g, w_b} = r_color;
      2'd1: begin
        w_r = {r_s, 1'b0};
        w_b = 8'hFF - {r_s, 1'b0};
      end
      2'd2: begin
        w_r = w_x8 * 8'd6;
        w_g = w_y8 * 8'd5;
        w_b = {r_s, 1'b0};
      end
      default: begin
        if (w_x8[3] ^ w_y8[4]) begin
          w_r = 8'hFF;
          w_g = 8'hFF;
          w_b = 8'hFF;
        end
      end
    endcase
  end

  assign rgb        = (r_state == S_ACTIVE) ? {w_b, w_g, w_r} : 24'd0;
  assign hsync      = (r_state == S_ACTIVE);
  assign vsync      = (r_state == S_ACTIVE) || (r_state == S_HBLANK);
  assign slice_cnt  = r_s;
  assign frame_done = (r_state == S_HBLANK) && (r_x == X_LAST) && (r_y == Y_LAST) && (r_s == S_LAST);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_rgb_stream_gen.sv
// Bench for rgb_stream_gen: a reference word stream is queued per frame and compared word by word.
// A reduced frame geometry keeps the run short while still reaching x=8, y=16 and slice wrap.
module tb_rgb_stream_gen;

  localparam int HA = 40;
  localparam int HB = 4;
  localparam int VA = 17;
  localparam int SL = 4;
  localparam int VB = 8;
  localparam int FRAME_BUDGET = 12000;

  logic        clk;
  logic        nrst;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] solid_color;
  logic        full;
  logic        wr_en;
  logic [23:0] rgb;
  logic        hsync;
  logic        vsync;
  logic [6:0]  slice_cnt;
  logic        frame_done;
  logic [1:0]  dbg_state;

  rgb_stream_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .SLICES(SL), .H_BLANK(HB), .V_BLANK(VB)
  ) dut (
    .clk(clk), .nrst(nrst), .enable(enable), .mode(mode), .solid_color(solid_color),
    .full(full), .wr_en(wr_en), .rgb(rgb), .hsync(hsync), .vsync(vsync),
    .slice_cnt(slice_cnt), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {slice_dont_care, frame_done, vsync, hsync, slice[6:0], rgb[23:0]}
  logic [34:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int frames_seen = 0;
  int hx = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int m, input logic [23:0] c, input int x, input int y, input int s);
    logic [7:0] r, g, b;
    case (m)
      0: {r, g, b} = c;
      1: begin r = 8'(2 * s); g = 8'd0; b = 8'(255 - 2 * s); end
      2: begin r = 8'(6 * x); g = 8'(5 * y); b = 8'(2 * s); end
      default: begin
        r = ((((x / 8) + (y / 16)) % 2) == 1) ? 8'hFF : 8'h00;
        g = r;
        b = r;
      end
    endcase
    return {b, g, r};
  endfunction

  task automatic push_vblank();
    for (int i = 0; i < VB; i++) exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 24'd0});
  endtask

  task automatic push_frame(input int m, input logic [23:0] c);
    for (int s = 0; s < SL; s++)
      for (int y = 0; y < VA; y++)
        for (int x = 0; x < HA + HB; x++) begin
          logic act, fd;
          act = (x < HA);
          fd  = (s == SL - 1) && (y == VA - 1) && (x == HA + HB - 1);
          exp_q.push_back({1'b0, fd, 1'b1, act, 7'(s), act ? pix(m, c, x, y, s) : 24'd0});
        end
  endtask

  // monitor: pops one expected word per accepted write
  always @(negedge clk) begin
    if (nrst && wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {1'b1, frame_done, vsync, hsync, slice_cnt, rgb}, 64'd0);
      end else begin
        logic [34:0] e, got;
        e = exp_q.pop_front();
        got = {e[34], frame_done, vsync, hsync, slice_cnt, rgb};
        if (e[34]) begin
          got[30:24] = 7'd0;
          e[30:24]   = 7'd0;
        end
        check("word", got, e);
        if (e[33]) frames_seen++;
      end
      hx = hsync ? hx + 1 : 0;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      step();
      full = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    full = 1'b0;
  endtask

  task automatic wait_frames(input int target, input bit rnd);
    int n;
    n = 0;
    while (frames_seen < target && n < FRAME_BUDGET) begin
      step();
      full = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      n++;
    end
    full = 1'b0;
    check("frame_count", 64'(frames_seen), 64'(target));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < FRAME_BUDGET) begin
      step();
      n++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_wr_en", {62'd0, dbg_state == 2'd0, wr_en}, 64'd2);
    end
  endtask

  initial begin
    nrst = 1'b0;
    enable = 1'b0;
    mode = 2'd0;
    solid_color = 24'h0;
    full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {wr_en, hsync, vsync, frame_done, slice_cnt, rgb, dbg_state}, 64'd0);
    step();
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_after_reset", {62'd0, dbg_state, wr_en}, 64'd0);
    end

    // frame 1: solid colour, no back-pressure
    step();
    mode = 2'd0;
    solid_color = 24'h123456;
    enable = 1'b1;
    push_vblank();
    push_frame(0, 24'h123456);
    wait_frames(1, 1'b0);

    // frame 2: gradient under random back-pressure; mode change mid-frame is ignored
    mode = 2'd2;
    push_vblank();
    push_frame(2, 24'h0);
    run_cycles(600, 1'b1);
    mode = 2'd3;
    solid_color = 24'($urandom_range(0, 24'hFFFFFF));
    wait_frames(2, 1'b1);

    // frame 3: checkerboard, 10-cycle stall at x=20, enable dropped in slice 1
    push_vblank();
    push_frame(3, 24'h0);
    begin
      int n;
      n = 0;
      while (!(hx == 20 && hsync) && n < FRAME_BUDGET) begin
        step();
        n++;
      end
      check("reach_x20", {63'd0, hx == 20 && hsync}, 64'd1);
    end
    full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_wr_en", {63'd0, wr_en}, 64'd0);
      check("stall_hold", {vsync, hsync, frame_done, slice_cnt, rgb},
            {exp_q[0][32], exp_q[0][31], exp_q[0][33], exp_q[0][30:24], exp_q[0][23:0]});
      @(posedge clk);
      #1;
    end
    full = 1'b0;
    begin
      int n;
      n = 0;
      while (slice_cnt != 7'd1 && n < FRAME_BUDGET) begin
        step();
        n++;
      end
      check("reach_slice1", 64'(slice_cnt), 64'd1);
    end
    enable = 1'b0;
    wait_frames(3, 1'b0);
    push_vblank();
    wait_idle();

    // frame 4: re-enable from idle with the slice ramp pattern
    mode = 2'd1;
    enable = 1'b1;
    push_vblank();
    push_frame(1, 24'h0);
    wait_frames(4, 1'b0);
    enable = 1'b0;
    push_vblank();
    wait_idle();

    // reset mid-frame, then a clean frame
    mode = 2'd0;
    solid_color = 24'hABCDEF;
    enable = 1'b1;
    push_vblank();
    push_frame(0, 24'hABCDEF);
    run_cycles(300, 1'b0);
    nrst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midframe_reset", {wr_en, hsync, vsync, frame_done, slice_cnt, rgb, dbg_state}, 64'd0);
    step();
    nrst = 1'b1;
    push_vblank();
    push_frame(0, 24'hABCDEF);
    wait_frames(5, 1'b0);
    enable = 1'b0;
    push_vblank();
    wait_idle();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_stream_gen.md
Name: rgb_stream_gen

Overview:
- Synthetic RGB stream source; writes 26-bit words {vsync, hsync, rgb[23:0]} into the RGB input FIFO that the slice-receiving RGB logic drains.
- Provides bring-up and test frames without the SoC video path.
- Emits frames of SLICES slices; each slice is 5x3 µblocks of 8x16 pixels (40x48).
- Stream format is exactly what the RGB logic decodes: vsync rising edge marks frame start; a pixel is counted when vsync && hsync.

Parameters:
- H_ACTIVE, 40, active pixels per line (5 block cols x 8).
- V_ACTIVE, 48, lines per slice (3 block lines x 16).
- SLICES, 128, slices per frame; 7-bit slice counter.
- H_BLANK, 4, hsync-low words after each line.
- V_BLANK, 8, vsync-low words between frames; must be >= 1.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- enable  in  1  run request, level sensitive.
- mode  in  2  pattern select, latched at frame start.
- solid_color  in  24  {R,G,B} for mode 0, latched at frame start.
- full  in  1  FIFO full.
- wr_en  out  1  FIFO write strobe.
- rgb  out  24  pixel word, byte order {B,G,R}; the receiver swaps it back to {R,G,B}.
- hsync  out  1  high on active pixel words.
- vsync  out  1  high on every word of a frame (active and H_BLANK words).
- slice_cnt  out  7  current slice index.
- frame_done  out  1  one-cycle pulse on the last word of a frame.

Behaviour:
- Reset: FSM IDLE. All counters 0. wr_en, hsync, vsync, frame_done = 0. rgb = 0. Latched mode/colour = 0.
- Reset mid-frame aborts the frame with no completion pulse. The next frame starts with a full VBLANK.
- wr_en = (state != IDLE) && !full, combinational.
- rgb/hsync/vsync are driven combinationally from the FSM state and counters, and are valid whenever wr_en = 1.
- Counters and FSM advance only on cycles with wr_en = 1. While full = 1, every output except wr_en holds.
- Counters:
  - x: 0..H_ACTIVE+H_BLANK-1.
  - y: 0..V_ACTIVE-1.
  - s: 0..SLICES-1.
  - v: 0..V_BLANK-1.
- FSM states:
  - IDLE: no writes. enable = 1 -> VBLANK with v = 0.
  - VBLANK: word = vsync 0, hsync 0, rgb 0. On v == V_BLANK-1: enable = 1 -> ACTIVE (latch mode and solid_color; clear x, y, s); enable = 0 -> IDLE.
  - ACTIVE: word = vsync 1, hsync 1, pattern pixel. On x == H_ACTIVE-1 -> HBLANK.
  - HBLANK: word = vsync 1, hsync 0, rgb 0. On x == H_ACTIVE+H_BLANK-1, x wraps to 0, then:
    - y < V_ACTIVE-1: y++, -> ACTIVE.
    - y == V_ACTIVE-1 and s < SLICES-1: y = 0, s++, -> ACTIVE.
    - y == V_ACTIVE-1 and s == SLICES-1: frame_done asserted for this word, -> VBLANK with v = 0.
- enable dropping mid-frame does not truncate the frame. The generator finishes the frame, emits the full VBLANK, then goes IDLE.
- enable rising in VBLANK is honoured at the end of that VBLANK.
- Every frame is preceded by at least V_BLANK vsync-low words, so the receiver always sees a vsync rising edge.
- Patterns: x is the pixel column, y the line, s the slice. Values below are {R,G,B}, 8 bits each, truncated mod 256:
  - 0: solid_color.
  - 1: R = 2s, G = 0, B = 255-2s.
  - 2: R = 6x, G = 5y, B = 2s.
  - 3: (x/8 + y/16) odd -> FFFFFF, else 000000 (µblock checkerboard).
- Output mapping: rgb = {B,G,R}.
- slice_cnt = s.
- Words per frame (defaults) = SLICES*V_ACTIVE*(H_ACTIVE+H_BLANK) = 270336.

Test Plan:
- Reset, enable = 1, full = 0, mode 0, solid_color 0x123456 -> first 8 words vsync = 0. Word 9 is vsync 1, hsync 1, rgb 0x563412. Words 49..52 are hsync 0, rgb 0. frame_done fires on word 8+270336.
- Mode 2, s = 0: word at y = 1, x = 3 -> R = 18, G = 5, B = 0, so rgb = 0x000512. At s = 127, B = 0xFE.
- Mode 3: x = 8, y = 0 -> FFFFFF. x = 8, y = 16 -> 000000. x = 0, y = 16 -> FFFFFF.
- Hold full = 1 for 10 cycles mid-line at x = 20 -> wr_en = 0 throughout and outputs hold. After release, the next word is x = 20 with no pixel lost or duplicated. Total frame word count is unchanged.
- Drop enable at s = 5 -> frame completes through s = 127, frame_done pulses, 8 VBLANK words follow, then IDLE with wr_en = 0. Re-enable -> 8 VBLANK words, then a new frame.
- Change mode mid-frame -> pattern unchanged until the next frame's first active word. Loop back through the RGB logic: EOS count is 128 per frame and block coordinates wrap at (7, 15, 4, 2).
